// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: synchronises hsync/vsync/blank, rebuilds the x/y position,
// measures line and frame length and declares lock once the timing matches the expected mode.
module vga_sync_decoder #(
    parameter int CNT_W       = 10,
    parameter int EXP_H_TOTAL = 264,
    parameter int EXP_V_TOTAL = 628,
    parameter int LOCK_FRAMES = 3,
    parameter int SYNC_POL    = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             blank_in,
    output logic [CNT_W-1:0] x_pos,
    output logic [CNT_W-1:0] y_pos,
    output logic             active,
    output logic [CNT_W-1:0] line_len,
    output logic [CNT_W-1:0] frame_lines,
    output logic             line_start,
    output logic             frame_start,
    output logic             locked,
    output logic             h_err,
    output logic             v_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] EXP_H   = CNT_W'(EXP_H_TOTAL);
    localparam logic [CNT_W-1:0] EXP_V   = CNT_W'(EXP_V_TOTAL);
    localparam logic [3:0]       LOCK_N  = 4'(LOCK_FRAMES);
    localparam logic             INV     = (SYNC_POL == 0);
    // Synchroniser reset value is the idle line level, so no false edge follows reset.
    localparam logic [2:0]       SYNC_RST = {1'b1, INV, INV};

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    // {blank, vsync, hsync} through the 2-FF synchroniser
    logic [2:0]       sync1_q, sync1_d;
    logic [2:0]       sync2_q, sync2_d;
    logic             h_dly_q, h_dly_d;
    logic             v_dly_q, v_dly_d;
    logic             h_norm, v_norm, h_rise, v_rise;

    logic [CNT_W-1:0] x_pos_q, x_pos_d;
    logic [CNT_W-1:0] y_pos_q, y_pos_d;
    logic [CNT_W-1:0] line_len_q, line_len_d;
    logic [CNT_W-1:0] frame_lines_q, frame_lines_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic             active_q, active_d;
    logic             line_ok_q, line_ok_d;
    logic             first_q, first_d;
    logic             line_fail, frame_good, timeout;

    state_t           state_q;
    logic [3:0]       good_cnt_q;
    logic             locked_q, h_err_q, v_err_q;

    always_comb begin
        sync1_d = {blank_in, vsync_in, hsync_in};
        sync2_d = sync1_q;
        h_norm  = sync2_q[0] ^ INV;
        v_norm  = sync2_q[1] ^ INV;
        h_dly_d = h_norm;
        v_dly_d = v_norm;
        h_rise  = h_norm & ~h_dly_q;
        v_rise  = v_norm & ~v_dly_q;

        line_start_d  = h_rise;
        frame_start_d = v_rise;
        active_d      = ~sync2_q[2];

        x_pos_d    = x_pos_q;
        line_len_d = line_len_q;
        if (h_rise) begin
            line_len_d = (x_pos_q == CNT_MAX) ? CNT_MAX : x_pos_q + 1'b1;
            x_pos_d    = '0;
        end else if (x_pos_q != CNT_MAX) begin
            x_pos_d = x_pos_q + 1'b1;
        end

        // A line edge coincident with the frame edge closes the old frame.
        y_pos_d       = y_pos_q;
        frame_lines_d = frame_lines_q;
        if (v_rise) begin
            frame_lines_d = (h_rise && y_pos_q != CNT_MAX) ? y_pos_q + 1'b1 : y_pos_q;
            y_pos_d       = '0;
        end else if (h_rise && y_pos_q != CNT_MAX) begin
            y_pos_d = y_pos_q + 1'b1;
        end

        // The first line measured after a frame edge may be partial, so it is not judged.
        line_fail = line_start_q && !first_q && (line_len_q != EXP_H);
        line_ok_d = line_ok_q;
        first_d   = first_q;
        if (frame_start_q) begin
            line_ok_d = 1'b1;
            first_d   = 1'b1;
        end else begin
            if (line_fail)    line_ok_d = 1'b0;
            if (line_start_q) first_d   = 1'b0;
        end

        frame_good = (frame_lines_q == EXP_V) && line_ok_q && !line_fail;
        timeout    = (x_pos_q == CNT_MAX);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q       <= SYNC_RST;
            sync2_q       <= SYNC_RST;
            h_dly_q       <= 1'b0;
            v_dly_q       <= 1'b0;
            x_pos_q       <= '0;
            y_pos_q       <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            active_q      <= 1'b0;
            line_ok_q     <= 1'b0;
            first_q       <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            h_dly_q       <= h_dly_d;
            v_dly_q       <= v_dly_d;
            x_pos_q       <= x_pos_d;
            y_pos_q       <= y_pos_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            active_q      <= active_d;
            line_ok_q     <= line_ok_d;
            first_q       <= first_d;
        end
    end

    // Lock FSM; the error pulses default low every cycle so they never stretch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= SEARCH;
            good_cnt_q <= '0;
            locked_q   <= 1'b0;
            h_err_q    <= 1'b0;
            v_err_q    <= 1'b0;
        end else begin
            h_err_q <= 1'b0;
            v_err_q <= 1'b0;
            if (timeout) begin
                state_q  <= SEARCH;
                locked_q <= 1'b0;
            end else begin
                case (state_q)
                    SEARCH: begin
                        if (frame_start_q) begin
                            state_q    <= ACQUIRE;
                            good_cnt_q <= '0;
                        end
                    end
                    ACQUIRE: begin
                        if (frame_start_q) begin
                            if (!frame_good) begin
                                good_cnt_q <= '0;
                            end else if (good_cnt_q + 4'd1 >= LOCK_N) begin
                                good_cnt_q <= LOCK_N;
                                state_q    <= LOCKED;
                                locked_q   <= 1'b1;
                            end else begin
                                good_cnt_q <= good_cnt_q + 4'd1;
                            end
                        end
                    end
                    LOCKED: begin
                        if ((line_start_q && line_len_q != EXP_H) ||
                            (frame_start_q && frame_lines_q != EXP_V)) begin
                            h_err_q  <= line_start_q && (line_len_q != EXP_H);
                            v_err_q  <= frame_start_q && (frame_lines_q != EXP_V);
                            locked_q <= 1'b0;
                            state_q  <= SEARCH;
                        end
                    end
                    default: begin
                        state_q  <= SEARCH;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign x_pos       = x_pos_q;
    assign y_pos       = y_pos_q;
    assign active      = active_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign h_err       = h_err_q;
    assign v_err       = v_err_q;

endmodule
